// File: rtl/sd_clk_pkg.sv
// sd_clk_pkg: shared state encoding and divisor constants for the SD clock generator
package sd_clk_pkg;
  typedef enum logic [1:0] {STOPPED, RUN, DRAIN} state_t;
  localparam int DIV_W_DEF    = 16;
  localparam int DIV_400K_50M = 62;
  localparam int DIV_25M_50M  = 0;
endpackage

// File: rtl/sd_clk_gen.sv
// sd_clk_gen: run-time programmable SD card clock with glitch-free divisor updates and stop/start
// Ports:
//   i_clk      system clock, all logic on rising edge
//   i_reset    synchronous active-low reset
//   i_clk_en   level request to run sd_clk
//   i_div      half period minus one, in i_clk cycles
//   i_div_wr   one-cycle pulse capturing i_div
//   o_div_busy written divisor pending, not yet applied
//   o_sd_clk   registered SD clock
//   o_sd_rise  high in the cycle o_sd_clk goes 0->1
//   o_sd_fall  high in the cycle o_sd_clk goes 1->0
//   o_running  generator is not stopped
//   i_stall / o_stalled  low-phase hold, present only with SD_CLK_STALL_EN defined
module sd_clk_gen
  import sd_clk_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DIV_RESET = DIV_400K_50M
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_div_wr,
`ifdef SD_CLK_STALL_EN
  input  logic             i_stall,
  output logic             o_stalled,
`endif
  output logic             o_div_busy,
  output logic             o_sd_clk,
  output logic             o_sd_rise,
  output logic             o_sd_fall,
  output logic             o_running
);
  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_pend;
  logic             r_busy;
  logic             r_sd_clk;
  logic             r_rise;
  logic             r_fall;
  logic             r_running;
  logic             w_stall;
  logic             w_tick;
  logic             w_low_stop;
  logic             w_hold;
  logic             w_end;
  logic [DIV_W-1:0] w_div_stop;
  logic [DIV_W-1:0] w_div_fall;
`ifdef SD_CLK_STALL_EN
  logic             r_stalled;
  assign w_stall   = i_stall;
  assign o_stalled = r_stalled;
`else
  assign w_stall   = 1'b0;
`endif
  assign w_tick     = r_cnt == r_div_q;
  // stopping is only allowed from the low phase; high phases always finish
  assign w_low_stop = r_state == RUN && !r_sd_clk && !i_clk_en;
  assign w_hold     = r_state == RUN && !r_sd_clk && w_stall;
  assign w_end      = r_state == DRAIN || !i_clk_en;
  // on entry to STOPPED a same-cycle write wins over an older pending value
  assign w_div_stop = i_div_wr ? i_div : (r_busy ? r_pend : r_div_q);
  assign w_div_fall = r_busy ? r_pend : r_div_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= STOPPED;
      r_cnt     <= '0;
      r_div_q   <= DIV_W'(DIV_RESET);
      r_pend    <= DIV_W'(DIV_RESET);
      r_busy    <= 1'b0;
      r_sd_clk  <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_running <= 1'b0;
`ifdef SD_CLK_STALL_EN
      r_stalled <= 1'b0;
`endif
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
`ifdef SD_CLK_STALL_EN
      r_stalled <= 1'b0;
`endif
      if (r_state == STOPPED) begin
        r_sd_clk <= 1'b0;
        r_cnt    <= '0;
        if (i_div_wr) r_div_q <= i_div;
        if (i_clk_en) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
      end else begin
        if (i_div_wr) begin
          r_pend <= i_div;
          r_busy <= 1'b1;
        end
        if (w_low_stop) begin
          r_state   <= STOPPED;
          r_running <= 1'b0;
          r_cnt     <= '0;
          r_div_q   <= w_div_stop;
          r_busy    <= 1'b0;
        end else if (w_hold) begin
          r_cnt <= '0;
`ifdef SD_CLK_STALL_EN
          r_stalled <= 1'b1;
`endif
        end else if (w_tick) begin
          r_cnt    <= '0;
          r_sd_clk <= !r_sd_clk;
          r_rise   <= !r_sd_clk;
          r_fall   <= r_sd_clk;
          // divisor changes only at a fall, so the next low phase uses the new value
          if (r_sd_clk) begin
            if (w_end) begin
              r_state   <= STOPPED;
              r_running <= 1'b0;
              r_div_q   <= w_div_stop;
              r_busy    <= 1'b0;
            end else begin
              r_div_q <= w_div_fall;
              r_busy  <= i_div_wr;
            end
          end
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
          if (r_sd_clk && !i_clk_en) r_state <= DRAIN;
        end
      end
    end
  end
  assign o_div_busy = r_busy;
  assign o_sd_clk   = r_sd_clk;
  assign o_sd_rise  = r_rise;
  assign o_sd_fall  = r_fall;
  assign o_running  = r_running;
endmodule

// File: tb/tb_sd_clk_gen.sv
// tb_sd_clk_gen: randomized and directed check of sd_clk_gen against a countdown reference model
module tb_sd_clk_gen;
  localparam int W  = 16;
  localparam int DR = 62;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         en = 0;
  logic         wr = 0;
  logic         st = 0;
  logic [W-1:0] d = '0;
  logic         busy, sdc, rise, fall, running;
`ifdef SD_CLK_STALL_EN
  logic         stalled;
`endif
  sd_clk_gen dut (
    .i_clk(clk), .i_reset(rst_n), .i_clk_en(en), .i_div(d), .i_div_wr(wr),
`ifdef SD_CLK_STALL_EN
    .i_stall(st), .o_stalled(stalled),
`endif
    .o_div_busy(busy), .o_sd_clk(sdc), .o_sd_rise(rise), .o_sd_fall(fall), .o_running(running)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int t = 0;
  int rises[$];
  int falls[$];
  bit busy_seen;
  bit m_act, m_drain, m_lvl, m_rise, m_fall, m_busy, m_stl;
  int m_left, m_div, m_pend;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0d", tag, act, exp, t);
    end
  endtask
  // reference: each half phase lasts div+1 cycles, counted down from entry
  task automatic model(input bit e, input bit w, input bit s, input int dv);
    bit ob = m_busy;
    int op = m_pend;
    m_rise = 0;
    m_fall = 0;
    m_stl = 0;
    if (!m_act) begin
      m_lvl = 0;
      if (w) m_div = dv;
      if (e) begin
        m_act = 1;
        m_left = m_div + 1;
      end
    end else begin
      if (w) begin
        m_pend = dv;
        m_busy = 1;
      end
      if (!m_lvl && !e) begin
        m_act = 0;
        m_div = w ? dv : (ob ? op : m_div);
        m_busy = 0;
      end else if (!m_lvl && s) begin
        m_left = m_div + 1;
        m_stl = 1;
      end else begin
        if (m_lvl && !e) m_drain = 1;
        m_left--;
        if (m_left == 0) begin
          m_rise = !m_lvl;
          m_fall = m_lvl;
          m_lvl = !m_lvl;
          if (m_fall) begin
            if (ob) m_div = op;
            m_busy = w;
            if (m_drain) begin
              m_act = 0;
              m_drain = 0;
              m_busy = 0;
              if (w) m_div = dv;
            end
          end
          m_left = m_div + 1;
        end
      end
    end
  endtask
  task automatic compare();
    check("sd_clk", sdc, m_lvl);
    check("sd_rise", rise, m_rise);
    check("sd_fall", fall, m_fall);
    check("running", running, m_act);
    check("div_busy", busy, m_busy);
`ifdef SD_CLK_STALL_EN
    check("stalled", stalled, m_stl);
`endif
  endtask
  task automatic cyc(input bit e, input bit w = 0, input int dv = 0, input bit s = 0);
    en = e;
    wr = w;
    d = W'(dv);
    st = s;
    @(posedge clk);
    t++;
    model(e, w, s, dv);
    #1;
    compare();
    if (rise) rises.push_back(t);
    if (fall) falls.push_back(t);
    if (busy) busy_seen = 1;
  endtask
  task automatic rst_cyc();
    rst_n = 0;
    en = 0;
    wr = 0;
    st = 0;
    @(posedge clk);
    m_act = 0; m_drain = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
    m_busy = 0; m_stl = 0; m_left = 0; m_div = DR; m_pend = DR;
    #1;
    compare();
    rst_n = 1;
    t = 0;
    rises.delete();
    falls.delete();
    busy_seen = 0;
  endtask
  initial begin
    int r0, r1, f0, tf, tr;
    bit ok;
    // identification clock from reset divisor
    rst_cyc();
    cyc(1);
    check("run_entry", running, 1);
    repeat (195) cyc(1);
    r0 = rises.size() > 0 ? rises[0] : -1;
    r1 = rises.size() > 1 ? rises[1] : -1;
    f0 = falls.size() > 0 ? falls[0] : -1;
    check("first_rise", r0, 64);
    check("high_len", f0 - r0, 63);
    check("period", r1 - r0, 126);
    // divisor written while stopped applies at once
    rst_cyc();
    cyc(0, 1, 1);
    repeat (40) cyc(1);
    r0 = rises.size() > 0 ? rises[0] : -1;
    r1 = rises.size() > 1 ? rises[1] : -1;
    f0 = falls.size() > 0 ? falls[0] : -1;
    check("fast_period", r1 - r0, 4);
    check("fast_high", f0 - r0, 2);
    check("busy_never", busy_seen, 0);
    // write while high stays pending until the fall
    rst_cyc();
    cyc(0, 1, 3);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc(1);
      ok = sdc;
    end
    check("wait_high", ok, 1);
    cyc(1, 1, 0);
    check("busy_high", busy, 1);
    repeat (30) cyc(1);
    // drop enable just after a rise
    rst_cyc();
    cyc(0, 1, 5);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc(1);
      ok = rise;
    end
    check("wait_rise", ok, 1);
    cyc(1);
    repeat (20) cyc(0);
    r0 = rises.size() > 0 ? rises[rises.size()-1] : -1;
    f0 = falls.size() > 0 ? falls[falls.size()-1] : -1;
    check("drain_high", f0 - r0, 6);
    check("drain_stop", running, 0);
    // write coincident with a fall while another value is pending
    rst_cyc();
    cyc(0, 1, 3);
    repeat (10) cyc(1);
    cyc(1, 1, 2);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      ok = m_lvl && m_left == 1;
      if (!ok) cyc(1);
    end
    check("wait_prefall", ok, 1);
    cyc(1, 1, 7);
    tf = t;
    check("pend_kept", busy, 1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc(1);
      ok = rise;
    end
    check("low_after_2", t - tf, 3);
    repeat (40) cyc(1);
`ifdef SD_CLK_STALL_EN
    // stall held through the low phase
    rst_cyc();
    cyc(0, 1, 4);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cyc(1);
      ok = fall;
    end
    check("wait_fall", ok, 1);
    cyc(1);
    cyc(1);
    repeat (20) cyc(1, 0, 0, 1);
    check("stall_low", sdc, 0);
    tr = t + 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc(1);
      ok = rise;
    end
    check("stall_release", t - tr, 4);
`else
    tr = 0;
`endif
    // random traffic
    rst_cyc();
    for (int i = 0; i < 3000; i++) begin
      bit e, w, s;
      int dv;
      if ($urandom_range(0, 499) == 0) rst_cyc();
      e = $urandom_range(0, 9) != 0;
      w = $urandom_range(0, 9) == 0;
      dv = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom_range(0, 4);
`ifdef SD_CLK_STALL_EN
      s = $urandom_range(0, 6) == 0;
`else
      s = 0;
`endif
      cyc(e, w, dv, s);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
Parametrised, run-time programmable SD card clock generator. It is the successor to the fixed-ratio divider in the SD host controller.
- Produces a registered 50%-duty sd_clk from the system clock, plus one-cycle rise and fall strobes for the command/data shifters.
- Divisor changes and clock stop/start happen only at safe phase boundaries, so sd_clk has no runt pulses.
- Sits between the host register block (divisor, enable) and the CMD/DAT line engines.

Parameters:
DIV_W, 16, width of the divisor and of the phase counter.
DIV_RESET, 62, divisor loaded at reset (about 400 kHz identification clock from 50 MHz).

Ports:
clk       input   1      system clock; all logic on its rising edge
reset     input   1      synchronous, active-low reset
clk_en    input   1      level request to run sd_clk
div       input   DIV_W  half-period minus one, in clk cycles
div_wr    input   1      one-cycle pulse; captures div
div_busy  output  1      a written divisor is pending, not yet applied
sd_clk    output  1      SD card clock, registered
sd_rise   output  1      strobe, high in the cycle sd_clk goes 0->1
sd_fall   output  1      strobe, high in the cycle sd_clk goes 1->0
running   output  1      state is not STOPPED

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=STOPPED, sd_clk=0, sd_rise=0, sd_fall=0, running=0, div_busy=0.
  - cnt=0, div_q=DIV_RESET.
  - A reset asserted mid-high-phase forces sd_clk low immediately. This truncated pulse is accepted.
- Timing:
  - Half period = div_q+1 clk cycles; full period = 2*(div_q+1).
  - div_q=0 gives clk/2. div_q=2^DIV_W-1 is the slowest setting.
  - cnt is DIV_W bits and is compared for equality with div_q only, so it never wraps.
- STOPPED:
  - sd_clk=0, cnt=0.
  - div_wr loads div_q directly on the next edge; div_busy stays 0.
  - If clk_en=1, go to RUN with cnt=0.
- RUN:
  - If cnt==div_q: toggle sd_clk, cnt<=0, pulse sd_rise or sd_fall to match the transition. Otherwise cnt<=cnt+1.
  - First sd_rise comes div_q+1 cycles after RUN entry, i.e. a full low phase precedes the first edge.
  - If clk_en=0 while sd_clk is low: go to STOPPED next edge, no strobe.
  - If clk_en=0 while sd_clk is high: go to DRAIN.
- DRAIN:
  - Keep counting to the end of the high phase. At the fall: sd_fall pulses, sd_clk=0, go to STOPPED.
  - clk_en returning to 1 during DRAIN is ignored; it is honoured from STOPPED.
  - High phases are never shortened.
- Divisor update while running:
  - div_wr captures div into div_pend and sets div_busy.
  - div_pend is copied to div_q at the edge that performs a fall toggle, and div_busy clears there.
  - A div_wr in the same cycle as a fall toggle loads div_pend and stays pending until the next fall.
  - A repeated div_wr while busy overwrites div_pend; last write wins.
  - Entering STOPPED from DRAIN applies any pending value, then clears div_busy.
- Strobes are mutually exclusive and never asserted in STOPPED.

Optional Feature:
Macro SD_CLK_STALL_EN.
- Defined:
  - Adds input stall (1) and output stalled (1).
  - In RUN with sd_clk low and stall=1: cnt is held at 0, sd_clk is held low, no strobes, stalled=1.
  - When stall returns to 0, a full low phase of div_q+1 cycles runs before the next rise.
  - A stall raised during a high phase takes effect after the fall completes normally.
  - Used to back-pressure the card when the data FIFO is full or empty.
- Undefined: no stall/stalled ports; behaviour is identical to stall=0.

Decomposition:
- Package sd_clk_pkg holds:
  - state enum {STOPPED, RUN, DRAIN};
  - DIV_400K_50M=62 and DIV_25M_50M=0 constants;
  - default DIV_W.
- Single module; no sub-module is natural. The counter, FSM and pending-divisor register are all tightly coupled.

Test Plan:
- Reset released, clk_en=1 at cycle 0 -> running=1 at cycle 1; first sd_rise 63 cycles after RUN entry; period 126 cycles; duty exactly 63/63.
- STOPPED, div_wr with div=1, then clk_en=1 -> sd_clk period 4 cycles, strobes alternate every 2 cycles, div_busy never asserted.
- Running at div_q=3: div_wr div=0 while sd_clk high -> div_busy=1 until the fall; the following low phase is 1 cycle; no high phase shorter than 4 cycles.
- clk_en dropped 1 cycle after a rise at div_q=5 -> sd_clk stays high for the full 6 cycles, then sd_fall, then running=0; no further strobes.
- div_wr coincident with a fall toggle (div=7, previous pending 2) -> 2 applied at that fall, 7 applied at the next fall.
- SD_CLK_STALL_EN: stall=1 for 20 cycles starting mid-low-phase at div_q=4 -> sd_clk low throughout, stalled=1; the first rise comes 5 cycles after stall drops.
